// File: rtl/program_loader_pkg.sv
// Shared definitions for the UART program loader: state encodings, the
// frame sync byte and the default UART bit period.
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE            = 8'hA5;
    localparam int         DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid / frame_error strobes.
module uart_rx
    import program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data   = shift_q;
    assign byte_valid  = valid_q;
    assign frame_error = ferr_q;

endmodule

// File: rtl/program_loader.sv
// Receives a checksummed program image over UART and writes it word by word
// into instruction memory while holding the CPU in reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] im_address,
    output logic [15:0] im_data,
    output logic        im_wren,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    localparam int               TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int               TMO_W        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT    = TMO_W'(TIMEOUT_CLKS);

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_error;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .frame_error (frame_error)
    );

    loader_state_e    state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       csum_q, csum_d;
    logic [15:0]      word_count_q, word_count_d;
    logic             im_wren_q, im_wren_d;
    logic [15:0]      im_address_q, im_address_d;
    logic [15:0]      im_data_q, im_data_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             in_frame;
    logic             timed_out;
    logic [15:0]      next_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            hi_q         <= '0;
            csum_q       <= '0;
            word_count_q <= '0;
            im_wren_q    <= 1'b0;
            im_address_q <= '0;
            im_data_q    <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            csum_q       <= csum_d;
            word_count_q <= word_count_d;
            im_wren_q    <= im_wren_d;
            im_address_q <= im_address_d;
            im_data_q    <= im_data_d;
            tmo_q        <= tmo_d;
        end
    end

    assign in_frame   = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
    assign timed_out  = in_frame && (tmo_q == TMO_LIMIT);
    assign next_count = word_count_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hi_d         = hi_q;
        csum_d       = csum_q;
        word_count_d = word_count_q;
        im_wren_d    = 1'b0;
        im_address_d = im_address_q;
        im_data_d    = im_data_q;
        tmo_d        = tmo_q;

        // The address counter advances the cycle after its write strobe.
        if (im_wren_q) begin
            word_count_d = next_count;
        end

        if (!in_frame || byte_valid) begin
            tmo_d = '0;
        end else if (!timed_out) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (!in_frame) begin
            if (byte_valid && byte_data == SYNC_BYTE) begin
                state_d      = LEN_HI;
                word_count_d = '0;
                csum_d       = '0;
            end
        end else if (frame_error || timed_out) begin
            state_d = ERROR;
        end else if (byte_valid) begin
            csum_d = csum_q ^ byte_data;
            case (state_q)
                LEN_HI: begin
                    len_d[15:8] = byte_data;
                    state_d     = LEN_LO;
                end
                LEN_LO: begin
                    len_d[7:0] = byte_data;
                    state_d    = ({len_q[15:8], byte_data} == 16'd0) ? CHECK : DATA_HI;
                end
                DATA_HI: begin
                    hi_d    = byte_data;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    im_wren_d    = 1'b1;
                    im_address_d = word_count_q;
                    im_data_d    = {hi_q, byte_data};
                    state_d      = (next_count == len_q) ? CHECK : DATA_HI;
                end
                CHECK: begin
                    csum_d  = csum_q;
                    state_d = (byte_data == csum_q) ? DONE : ERROR;
                end
                default: state_d = ERROR;
            endcase
        end
    end

    assign im_wren    = im_wren_q;
    assign im_address = im_address_q;
    assign im_data    = im_data_q;
    assign word_count = word_count_q;
    assign cpu_hold   = in_frame;
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 Parameter TIMEOUT_BITS, default 64, idle bit-times allowed between bytes inside a frame before abort.
REQ-003 clock  input  1  sole clock; all state changes on posedge clock.
REQ-004 reset  input  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 rx  input  1  UART serial line, idle high, 8N1, LSB first.
REQ-006 im_address  output  16  instruction-memory word address for the write.
REQ-007 im_data  output  16  instruction word to write.
REQ-008 im_wren  output  1  one-cycle write strobe; address/data valid in same cycle.
REQ-009 cpu_hold  output  1  high while a frame is in progress; holds CPU controller in reset.
REQ-010 done  output  1  high after a frame completes with a good checksum; sticky until next frame starts.
REQ-011 error  output  1  high after a failed frame; sticky until next frame starts.
REQ-012 word_count  output  16  number of words written in current/last frame.

Function
REQ-013 Frame format SHALL be: sync 0xA5, length N (16 bits, high byte first), N words (high byte then low byte each), checksum byte = XOR of all length and data bytes.
REQ-014 rx SHALL pass through a two-flop synchronizer before use.
REQ-015 Receiver SHALL detect start on falling edge, re-check low at mid-bit (CLKS_PER_BIT/2), sample each data bit and the stop bit at mid-bit.
REQ-016 Start bit found high at mid-bit SHALL be discarded as a glitch, no byte produced.
REQ-017 Stop bit sampled low SHALL be a framing error.
REQ-018 Loader FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR: byte 0xA5 -> LEN_HI, clear done, error, word_count, running checksum; set cpu_hold; any other byte ignored.
REQ-020 LEN_HI -> LEN_LO -> DATA_HI on each byte; N = 0 SHALL go from LEN_LO directly to CHECK.
REQ-021 DATA_LO byte SHALL assert im_wren for exactly one cycle with im_address = word_count, im_data = {hi, lo}; word_count increments the following cycle.
REQ-022 After word N written -> CHECK; otherwise -> DATA_HI.
REQ-023 CHECK byte equal to running XOR -> DONE (done=1); unequal -> ERROR (error=1).
REQ-024 Framing error or inter-byte timeout in any non-idle state -> ERROR.
REQ-025 cpu_hold SHALL drop in the same cycle as entry to DONE or ERROR.
REQ-026 Words beyond address 0xFFFF cannot occur: N is 16-bit, so max address is N-1.
REQ-027 Byte completion latency: byte state effect SHALL occur no later than 2 cycles after stop-bit mid-sample.
REQ-028 done and error SHALL never be high simultaneously.

Reset
REQ-029 Reset low: FSM IDLE, receiver idle, im_wren=0, im_address=0, im_data=0, cpu_hold=0, done=0, error=0, word_count=0, synchronizer flops=1.
REQ-030 Reset mid-frame SHALL abandon the frame without a further write; already-written words remain in memory.

Structure
REQ-031 Shared package SHALL hold loader state encoding, SYNC_BYTE=0xA5, and default CLKS_PER_BIT.
REQ-032 One sub-module uart_rx (synchronizer, bit timer, shift register, byte_valid strobe, frame_error strobe) SHALL be instantiated; loader FSM stays in program_loader.

Verification
REQ-033 Frame A5 00 02 12 34 AB CD, checksum 0x00^0x02^0x12^0x34^0xAB^0xCD=0x42 -> writes [0]=0x1234, [1]=0xABCD, done=1, word_count=2.
REQ-034 Same frame with checksum 0x43 -> both writes occur, error=1, done=0.
REQ-035 Frame A5 00 00 00 -> no im_wren, done=1, cpu_hold high then low.
REQ-036 Stop bit forced low on third byte -> error=1, no writes, cpu_hold=0.
REQ-037 Line idle 70 bit-times after LEN_LO byte -> error=1; following good frame -> done=1, error=0.
REQ-038 Reset pulled low during DATA_LO of word 1 -> all outputs at reset values immediately, no write for word 1.
